// File: rtl/clkdiv_pkg.sv
`default_nettype none
// ============================================================================
// Module  : clkdiv_pkg
// Purpose : Shared defaults and types for the clock divider bank.
//           - C_CNT_W / C_DEF_DIV : default counter width and reset divisor
//           - chan_flags_t        : per-channel registered status record
//           - ch_width()          : channel-select width, max(1, clog2(n))
// Revision: 1.0 - initial release
// ============================================================================
package clkdiv_pkg;

    localparam int C_CNT_W   = 25;
    localparam int C_DEF_DIV = 10000;

    // Registered per-channel status bits that leave the channel as outputs.
    typedef struct packed {
        logic pend;     // a written divisor is waiting to be applied
        logic clk_out;  // divided clock
        logic tick;     // one-cycle period-start strobe
    } chan_flags_t;

    // Width of a channel index; a single channel still needs one select bit.
    function automatic int ch_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage
`default_nettype wire

// File: rtl/clk_div_chan.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_chan
// Purpose : One divider channel: period counter, active/pending divisor pair,
//           registered divided clock and period-start tick.
// Ports   : clk_in1  - clock (rising edge)
//           rst      - synchronous active-high reset
//           wr_hit   - write strobe already decoded for this channel
//           wr_div   - divisor carried by the write
//           sync     - force the wrap state this edge (tie low if unused)
//           clk_out  - divided clock, registered
//           tick     - period-start strobe, registered
//           pend     - written divisor awaiting application
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_chan
    import clkdiv_pkg::*;
#(
    parameter int CNT_W   = C_CNT_W,
    parameter int DEF_DIV = C_DEF_DIV
) (
    input  logic             clk_in1,
    input  logic             rst,
    input  logic             wr_hit,
    input  logic [CNT_W-1:0] wr_div,
    input  logic             sync,
    output logic             clk_out,
    output logic             tick,
    output logic             pend
);

    localparam logic [CNT_W-1:0] C_DEF_DIV_VAL = CNT_W'(DEF_DIV);
    localparam logic [CNT_W-1:0] C_ONE         = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div_act;
    logic [CNT_W-1:0] r_div_pend;
    chan_flags_t      r_flags;

    logic             w_running;
    logic             w_wrap;
    logic             w_boundary;
    logic             w_apply;
    logic             w_new_running;
    logic [CNT_W-1:0] w_div_act_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    chan_flags_t      w_flags_nxt;
    logic [CNT_W-1:0] w_div_pend_nxt;

    always_comb begin
        w_running     = (r_div_act > C_ONE);
        w_wrap        = w_running && (r_cnt == (r_div_act - C_ONE));
        // A stopped channel sits on a permanent boundary, so a pending
        // divisor is taken on the very next edge.
        w_boundary    = w_wrap || sync || !w_running;
        w_apply       = w_boundary && r_flags.pend;
        w_div_act_nxt = w_apply ? r_div_pend : r_div_act;
        w_new_running = (w_div_act_nxt > C_ONE);
        w_cnt_nxt     = w_boundary ? '0 : (r_cnt + C_ONE);

        w_flags_nxt         = r_flags;
        // A period start is only announced when a running channel wraps into
        // a divisor that keeps it running; switching to 0/1 stops it silently.
        w_flags_nxt.tick    = w_running && (w_wrap || sync) && w_new_running;
        w_flags_nxt.clk_out = (w_cnt_nxt < (w_div_act_nxt >> 1));
        // A write on an application edge survives as the next pending value.
        if (wr_hit) begin
            w_flags_nxt.pend = 1'b1;
        end else if (w_apply) begin
            w_flags_nxt.pend = 1'b0;
        end
        w_div_pend_nxt = wr_hit ? wr_div : r_div_pend;
    end

    always_ff @(posedge clk_in1) begin
        if (rst) begin
            r_cnt      <= '0;
            r_div_act  <= C_DEF_DIV_VAL;
            r_div_pend <= C_DEF_DIV_VAL;
            r_flags    <= '0;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_div_act  <= w_div_act_nxt;
            r_div_pend <= w_div_pend_nxt;
            r_flags    <= w_flags_nxt;
        end
    end

    assign clk_out = r_flags.clk_out;
    assign tick    = r_flags.tick;
    assign pend    = r_flags.pend;

endmodule
`default_nettype wire

// File: rtl/clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module  : clk_div_bank
// Purpose : Bank of NUM_CH independent programmable clock dividers sharing
//           one write port. New divisors are staged and take effect at the
//           end of the period in flight.
// Ports   : clk_in1  - clock (rising edge)
//           rst      - synchronous active-high reset
//           wr_en    - divisor write strobe
//           wr_ch    - target channel (out-of-range values are ignored)
//           wr_div   - new divisor
//           sync     - (CLKDIV_SYNC_EN only) realign all channels to wrap
//           clk_out  - divided clock per channel
//           tick     - period-start strobe per channel
//           pend     - pending-divisor flag per channel
// Config  : define CLKDIV_SYNC_EN to add the sync input.
// Revision: 1.0 - initial release
// ============================================================================
module clk_div_bank
    import clkdiv_pkg::*;
#(
    parameter  int NUM_CH  = 2,
    parameter  int CNT_W   = C_CNT_W,
    parameter  int DEF_DIV = C_DEF_DIV,
    localparam int CH_W    = ch_width(NUM_CH)
) (
    input  logic              clk_in1,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [CH_W-1:0]   wr_ch,
    input  logic [CNT_W-1:0]  wr_div,
`ifdef CLKDIV_SYNC_EN
    input  logic              sync,
`endif
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pend
);

    logic w_sync;

`ifdef CLKDIV_SYNC_EN
    assign w_sync = sync;
`else
    assign w_sync = 1'b0;
`endif

    for (genvar g = 0; g < NUM_CH; g++) begin : g_chan
        logic w_wr_hit;

        // Exact index match: codes at or above NUM_CH select nothing.
        assign w_wr_hit = wr_en && (wr_ch == CH_W'(g));

        clk_div_chan #(
            .CNT_W   (CNT_W),
            .DEF_DIV (DEF_DIV)
        ) u_chan (
            .clk_in1 (clk_in1),
            .rst     (rst),
            .wr_hit  (w_wr_hit),
            .wr_div  (wr_div),
            .sync    (w_sync),
            .clk_out (clk_out[g]),
            .tick    (tick[g]),
            .pend    (pend[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_clk_div_bank.sv
`default_nettype none
// ============================================================================
// Module  : tb_clk_div_bank
// Purpose : Self-checking bench for clk_div_bank (NUM_CH=2, CNT_W=8,
//           DEF_DIV=4) plus a 3-channel copy that only ever receives writes
//           addressed to channel 3, which must all be ignored.
// Revision: 1.0 - initial release
// ============================================================================
module tb_clk_div_bank;

    logic       clk_in1 = 1'b0;
    logic       rst     = 1'b1;
    logic       wr_en   = 1'b0;
    logic [0:0] wr_ch   = 1'b0;
    logic [7:0] wr_div  = 8'd0;
    logic       sync_s  = 1'b0;
    logic [1:0] wr_ch3  = 2'd3;
    logic [1:0] clk_out, tick, pend;
    logic [2:0] clk_out3, tick3, pend3;

    always #5 clk_in1 = ~clk_in1;

    clk_div_bank #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(4)) u_dut (
        .clk_in1 (clk_in1),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch),
        .wr_div  (wr_div),
`ifdef CLKDIV_SYNC_EN
        .sync    (sync_s),
`endif
        .clk_out (clk_out),
        .tick    (tick),
        .pend    (pend)
    );

    clk_div_bank #(.NUM_CH(3), .CNT_W(8), .DEF_DIV(4)) u_dut3 (
        .clk_in1 (clk_in1),
        .rst     (rst),
        .wr_en   (wr_en),
        .wr_ch   (wr_ch3),
        .wr_div  (wr_div),
`ifdef CLKDIV_SYNC_EN
        .sync    (sync_s),
`endif
        .clk_out (clk_out3),
        .tick    (tick3),
        .pend    (pend3)
    );

    typedef struct {
        string      nm;
        logic [1:0] co;
        logic [1:0] tk;
        logic [1:0] pd;
        logic       co3;
        logic       tk3;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   ph       = 0;   // edges since reset/sync, mod 4, for the untouched bank

    // Scoreboard monitor: one expectation per edge, compared mid-cycle.
    always @(negedge clk_in1) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            checks++;
            if (clk_out !== e.co || tick !== e.tk || pend !== e.pd ||
                clk_out3 !== {3{e.co3}} || tick3 !== {3{e.tk3}} || pend3 !== 3'b000) begin
                failures++;
                $display("FAIL %s: got clk_out=%b tick=%b pend=%b clk_out3=%b tick3=%b pend3=%b, want clk_out=%b tick=%b pend=%b clk_out3=%b tick3=%b pend3=000",
                         e.nm, clk_out, tick, pend, clk_out3, tick3, pend3,
                         e.co, e.tk, e.pd, {3{e.co3}}, {3{e.tk3}});
            end
        end
    end

    task automatic step(input logic rs, input logic sy, input logic we,
                        input logic ch, input logic [7:0] dv,
                        input logic [1:0] eco, input logic [1:0] etk,
                        input logic [1:0] epd, input string nm);
        exp_t e;
        logic sy_eff;
        rst    = rs;
        sync_s = sy;
        wr_en  = we;
        wr_ch  = ch;
        wr_div = dv;
        @(posedge clk_in1);
`ifdef CLKDIV_SYNC_EN
        sy_eff = sy;
`else
        sy_eff = 1'b0;
`endif
        if (rs || sy_eff) ph = 0;
        else              ph = (ph + 1) % 4;
        e.nm  = nm;
        e.co  = eco;
        e.tk  = etk;
        e.pd  = epd;
        e.co3 = !rs && (ph < 2);
        e.tk3 = !rs && (ph == 0);
        q.push_back(e);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "timeout");
    end

    initial begin
        // reset
        step(1,0,0,0,0, 2'b00,2'b00,2'b00, "reset0");
        step(1,0,0,0,0, 2'b00,2'b00,2'b00, "reset1");
        // free run, period 4: clk_out 1,0,0,1 and tick on edge 4
        step(0,0,0,0,0, 2'b11,2'b00,2'b00, "run_e1");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "run_e2");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "run_e3");
        step(0,0,0,0,0, 2'b11,2'b11,2'b00, "run_e4");
        step(0,0,0,0,0, 2'b11,2'b00,2'b00, "run_e5");
        // ch1 <- 5 with cnt=1, applied at the wrap
        step(0,0,1,1,5, 2'b00,2'b00,2'b10, "wr1_5");
        step(0,0,0,0,0, 2'b00,2'b00,2'b10, "pend1_hold");
        step(0,0,0,0,0, 2'b11,2'b11,2'b00, "apply1_5");
        step(0,0,0,0,0, 2'b11,2'b00,2'b00, "div5_e1");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "div5_e2");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "div5_e3");
        step(0,0,0,0,0, 2'b01,2'b01,2'b00, "div5_e4");
        step(0,0,0,0,0, 2'b11,2'b10,2'b00, "div5_wrap");
        // ch0 <- 0 then 6 before the wrap: only 6 is applied
        step(0,0,1,0,0, 2'b10,2'b00,2'b01, "wr0_0");
        step(0,0,1,0,6, 2'b00,2'b00,2'b01, "wr0_6");
        step(0,0,0,0,0, 2'b01,2'b01,2'b00, "apply0_6");
        step(0,0,0,0,0, 2'b01,2'b00,2'b00, "div6_e1");
        step(0,0,0,0,0, 2'b11,2'b10,2'b00, "div6_e2");
        // ch0 <- 1: stops at its next wrap
        step(0,0,1,0,1, 2'b10,2'b00,2'b01, "wr0_1");
        step(0,0,0,0,0, 2'b00,2'b00,2'b01, "div6_e4");
        step(0,0,0,0,0, 2'b00,2'b00,2'b01, "div6_e5");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "stop0");
        step(0,0,0,0,0, 2'b10,2'b10,2'b00, "stop0_hold1");
        step(0,0,0,0,0, 2'b10,2'b00,2'b00, "stop0_hold2");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "stop0_hold3");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "ch1_cnt3");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "ch1_cnt4");
        // write ch1 <- 3 on its wrap edge: applied one period later
        step(0,0,1,1,3, 2'b10,2'b10,2'b10, "wr1_on_wrap");
        step(0,0,0,0,0, 2'b10,2'b00,2'b10, "late_e1");
        step(0,0,0,0,0, 2'b00,2'b00,2'b10, "late_e2");
        step(0,0,0,0,0, 2'b00,2'b00,2'b10, "late_e3");
        step(0,0,0,0,0, 2'b00,2'b00,2'b10, "late_e4");
        step(0,0,0,0,0, 2'b10,2'b10,2'b00, "apply1_3");
        // restart stopped ch0 with 4: applied next edge, no tick
        step(0,0,1,0,4, 2'b00,2'b00,2'b01, "wr0_4");
        step(0,0,0,0,0, 2'b01,2'b00,2'b00, "restart0");
        step(0,0,0,0,0, 2'b11,2'b10,2'b00, "restart0_e1");
        // pending write discarded by reset, reset beats a same-edge write
        step(0,0,1,1,7, 2'b00,2'b00,2'b10, "wr1_7");
        step(1,0,1,1,9, 2'b00,2'b00,2'b00, "rst_mid");
        step(0,0,0,0,0, 2'b11,2'b00,2'b00, "rerun_e1");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "rerun_e2");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "rerun_e3");
        step(0,0,0,0,0, 2'b11,2'b11,2'b00, "rerun_e4");
        // put the channels out of phase (ch0 period 4, ch1 period 6)
        step(0,0,1,1,6, 2'b11,2'b00,2'b10, "wr1_6");
        step(0,0,0,0,0, 2'b00,2'b00,2'b10, "ph_e2");
        step(0,0,0,0,0, 2'b00,2'b00,2'b10, "ph_e3");
        step(0,0,0,0,0, 2'b11,2'b11,2'b00, "apply1_6");
        step(0,0,0,0,0, 2'b11,2'b00,2'b00, "ph_e5");
        step(0,0,0,0,0, 2'b10,2'b00,2'b00, "ph_e6");
        step(0,0,0,0,0, 2'b00,2'b00,2'b00, "ph_e7");
        step(0,0,0,0,0, 2'b01,2'b01,2'b00, "ph_e8");
        step(0,0,0,0,0, 2'b01,2'b00,2'b00, "ph_e9");
`ifdef CLKDIV_SYNC_EN
        step(0,1,0,0,0, 2'b11,2'b11,2'b00, "sync_pulse");
        step(0,0,0,0,0, 2'b11,2'b00,2'b00, "sync_after");
`else
        step(0,1,0,0,0, 2'b10,2'b10,2'b00, "nosync_e10");
        step(0,0,0,0,0, 2'b10,2'b00,2'b00, "nosync_e11");
`endif
        for (int i = 0; i < 4 && q.size() > 0; i++) @(negedge clk_in1);
        #1;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/clk_div_bank.md
CLK_DIV_BANK -- requirements
Module: clk_div_bank

Interface
REQ-001 Parameter NUM_CH, default 2, number of independent divider channels.
REQ-002 Parameter CNT_W, default 25, counter and divisor width in bits.
REQ-003 Parameter DEF_DIV, default 10000, divisor loaded into every channel at reset.
REQ-004 Local parameter CH_W SHALL equal max(1, clog2(NUM_CH)).
REQ-005 clk_in1  input  1  sole clock; all logic on its rising edge.
REQ-006 rst  input  1  reset; synchronous and active-high.
REQ-007 wr_en  input  1  divisor write strobe.
REQ-008 wr_ch  input  CH_W  target channel of the write.
REQ-009 wr_div  input  CNT_W  new divisor value.
REQ-010 clk_out  output  NUM_CH  divided clock per channel, registered.
REQ-011 tick  output  NUM_CH  one-cycle strobe per channel, registered, marks period start.
REQ-012 pend  output  NUM_CH  high while a written divisor awaits application.

Function
REQ-013 Each channel SHALL hold div_act (active divisor), div_pend (pending divisor), pend flag and cnt, all CNT_W bits except pend.
REQ-014 Running channel (div_act >= 2), each edge: cnt <= (cnt == div_act-1) ? 0 : cnt+1.
REQ-015 clk_out SHALL be registered as (cnt_next < div_act>>1): high for floor(div_act/2) cycles, then low for the rest of the period; odd divisors give a shorter high phase.
REQ-016 tick SHALL be registered high exactly on the edge where cnt wraps to 0, otherwise low.
REQ-017 Stopped channel (div_act of 0 or 1): cnt, clk_out and tick SHALL be held at 0.
REQ-018 wr_en with wr_ch < NUM_CH SHALL load div_pend and set pend on the next edge; wr_ch >= NUM_CH SHALL be ignored.
REQ-019 A second write before application SHALL overwrite div_pend; the last write wins.
REQ-020 For a running channel, pending divisor SHALL be applied only on the wrap edge (cnt == div_act-1): div_act <= div_pend, pend cleared, cnt <= 0, tick high, clk_out per new divisor. The period in flight is never truncated or stretched.
REQ-021 Stopped channel SHALL apply pending divisor on the next edge with cnt kept 0 and tick low, then count from 0.
REQ-022 A write landing on the same edge as an application SHALL be stored as the new div_pend with pend remaining set; the application uses the previous div_pend.
REQ-023 Channels SHALL be fully independent; a write to one channel never disturbs another.

Reset
REQ-024 While rst is high at an edge: cnt=0, clk_out=0, tick=0, pend=0, div_pend=DEF_DIV and div_act=DEF_DIV for all channels.
REQ-025 Reset mid-period or with a write pending SHALL discard the pending write; rst has priority over wr_en.
REQ-026 After rst drops, the first edge SHALL yield cnt=1; the first tick follows DEF_DIV edges after reset release.

Configuration
REQ-027 Macro CLKDIV_SYNC_EN, when defined, SHALL add input port sync (1 bit, after wr_div).
REQ-028 With the macro, sync high at an edge SHALL force every channel to the wrap state: cnt=0, tick=1 for running channels, clk_out per divisor, and any pending divisor applied. rst SHALL override sync.
REQ-029 Without the macro, there SHALL be no sync port, and behaviour SHALL equal sync tied low.

Structure
REQ-030 Package clkdiv_pkg SHALL hold default constants (CNT_W, DEF_DIV) and the channel state record typedef.
REQ-031 Per-channel logic SHALL be sub-module clk_div_chan, instantiated NUM_CH times by generate.

Verification (NUM_CH=2, CNT_W=8, DEF_DIV=4)
REQ-032 Reset, then free run -> ch0 clk_out is 1,0,0,1 on edges 1-4 after release, and tick is high only on edge 4, then every 4 edges.
REQ-033 Write ch1 div=5 at cnt=1 -> pend[1] is high until the wrap edge, then ch1 has period 5 with 2 high and 3 low, while ch0 is unchanged.
REQ-034 Write ch0 div=0, then div=6 before the wrap -> div 6 is applied at the wrap and 0 is never seen; then write div=1 -> the channel stops at the next wrap with outputs held at 0.
REQ-035 Write with wr_ch=3 -> no state change on any channel; write on the wrap edge -> applied one period later.
REQ-036 rst pulse mid-period with pend set -> all outputs 0, pend cleared, and restart with period 4.
REQ-037 Under CLKDIV_SYNC_EN, sync pulse with channels at different phases -> both channels show tick=1 on the same edge.
